// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select encodings
// and the prefetch queue entry layout.
package if_pkg;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_JAL  = 2'b10;
  localparam logic [1:0] PC_SEL_JALR = 2'b11;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  // Entry PC field is sized for the widest supported XLEN; narrower builds use the low bits.
  localparam int PC_W_MAX = 64;

  typedef struct packed {
    logic [PC_W_MAX-1:0] pc;
    logic [31:0]         insn;
    logic                filled;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Circular prefetch queue: entries are allocated at request time, filled in
// order by memory responses, and popped from the head once filled.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_alloc,
  input  logic [XLEN-1:0]  i_alloc_pc,
  input  logic             i_fill,
  input  logic [31:0]      i_fill_insn,
  input  logic             i_pop,
  output logic             o_head_valid,
  output logic [XLEN-1:0]  o_head_pc,
  output logic [31:0]      o_head_insn,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_unfilled
);

  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [PTR_W-1:0]    r_fill;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_unfilled;
  if_entry_t           w_entry [DEPTH];
  if_entry_t           w_head;
  logic [PC_W_MAX-1:0] w_unused_pc;
  logic                w_fill;
  logic                w_pop;

  assign w_head       = w_entry[r_head];
  assign w_unused_pc  = w_head.pc;
  assign o_head_valid = w_head.filled;
  assign o_head_pc    = w_head.pc[XLEN-1:0];
  assign o_head_insn  = w_head.insn;
  assign o_count      = r_count;
  assign o_unfilled   = r_unfilled;

  // A fill with nothing outstanding is a memory protocol error and is ignored.
  assign w_fill = i_fill && (r_unfilled != '0);
  assign w_pop  = i_pop && w_head.filled;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    if_entry_t r_e;

    always_ff @(posedge clk) begin
      if (rst || i_flush) begin
        r_e <= '0;
      end else begin
        if (w_pop && (r_head == PTR_W'(gi))) begin
          r_e.filled <= 1'b0;
        end
        if (i_alloc && (r_tail == PTR_W'(gi))) begin
          r_e.pc     <= PC_W_MAX'(i_alloc_pc);
          r_e.insn   <= '0;
          r_e.filled <= 1'b0;
        end
        if (w_fill && (r_fill == PTR_W'(gi))) begin
          r_e.insn   <= i_fill_insn;
          r_e.filled <= 1'b1;
        end
      end
    end

    assign w_entry[gi] = r_e;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
    end else begin
      if (i_alloc) r_tail <= r_tail + PTR_W'(1);
      if (w_fill)  r_fill <= r_fill + PTR_W'(1);
      if (w_pop)   r_head <= r_head + PTR_W'(1);
      r_count    <= r_count + CNT_W'(i_alloc) - CNT_W'(w_pop);
      r_unfilled <= r_unfilled + CNT_W'(i_alloc) - CNT_W'(w_fill);
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with next-PC selection and a DEPTH-entry prefetch queue.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stop,
  input  logic [1:0]      pc_sel_ex,
  input  logic            alu_branch,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] sext_ex,
  input  logic [XLEN-1:0] rD1_ex,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_redirect_cnt,
  output logic [XLEN-1:0] perf_stall_cnt
`endif
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  // Repeated redirects under a slow memory can stack several queue-loads of stale responses.
  localparam int DISC_W = $clog2(DEPTH) + 4;

  logic [XLEN-1:0]   r_fetch_pc;
  logic [DISC_W-1:0] r_discard;
  logic              w_redirect;
  logic [XLEN-1:0]   w_sum;
  logic [XLEN-1:0]   w_target;
  logic              w_req_valid;
  logic              w_alloc;
  logic              w_fill;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_unfilled;
  logic              w_head_valid;
  logic [XLEN-1:0]   w_head_pc;
  logic [31:0]       w_head_insn;

  always_comb begin
    w_redirect = 1'b0;
    w_sum      = pc_ex + sext_ex;
    case (pc_sel_ex)
      PC_SEL_SEQ:  w_redirect = 1'b0;
      PC_SEL_BR:   w_redirect = alu_branch;
      PC_SEL_JAL:  w_redirect = 1'b1;
      PC_SEL_JALR: begin
        w_redirect = 1'b1;
        w_sum      = (rD1_ex + sext_ex) & ~XLEN'(1);
      end
      default:     w_redirect = 1'b0;
    endcase
    w_target = {w_sum[XLEN-1:2], 2'b00};
  end

  assign w_req_valid = !rst && !w_redirect && (w_count < CNT_W'(DEPTH));
  assign w_alloc     = w_req_valid && imem_req_ready;
  assign w_fill      = imem_rsp_valid && (r_discard == '0) && !w_redirect;
  assign w_pop       = w_head_valid && !stop && !w_redirect;

  if_fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (w_redirect),
    .i_alloc      (w_alloc),
    .i_alloc_pc   (r_fetch_pc),
    .i_fill       (w_fill),
    .i_fill_insn  (imem_rsp_data),
    .i_pop        (w_pop),
    .o_head_valid (w_head_valid),
    .o_head_pc    (w_head_pc),
    .o_head_insn  (w_head_insn),
    .o_count      (w_count),
    .o_unfilled   (w_unfilled)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
    end else if (w_alloc) begin
      r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end
  end

  // Every request still in flight at a redirect becomes a response to throw away.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_discard <= '0;
    end else if (w_redirect) begin
      r_discard <= r_discard + DISC_W'(w_unfilled) - DISC_W'(imem_rsp_valid);
    end else if (imem_rsp_valid && (r_discard != '0)) begin
      r_discard <= r_discard - DISC_W'(1);
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign inst_valid     = w_head_valid;
  assign inst           = w_head_valid ? w_head_insn : '0;
  assign inst_pc        = w_head_valid ? w_head_pc : '0;

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] r_perf_fetch;
  logic [XLEN-1:0] r_perf_redirect;
  logic [XLEN-1:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch    <= '0;
      r_perf_redirect <= '0;
      r_perf_stall    <= '0;
    end else begin
      if (w_alloc)                r_perf_fetch    <= r_perf_fetch + XLEN'(1);
      if (w_redirect)             r_perf_redirect <= r_perf_redirect + XLEN'(1);
      if (w_head_valid && stop)   r_perf_stall    <= r_perf_stall + XLEN'(1);
    end
  end

  assign perf_fetch_cnt    = r_perf_fetch;
  assign perf_redirect_cnt = r_perf_redirect;
  assign perf_stall_cnt    = r_perf_stall;
`endif

endmodule
